// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified instruction/data memory between the CPU memory path and the
// debug/DMA loader. Each access holds the strobes for MEM_LATENCY cycles and then pulses ready.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MEM_LATENCY    = 2,
    parameter int unsigned MAX_CPU_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   streak_q, streak_d;
    logic               owner_q, owner_d;      // 1 = DMA owns the current access
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               dma_ready_q, dma_ready_d;
    logic               dma_wins;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            cpu_ready_q <= cpu_ready_d;
            dma_ready_q <= dma_ready_d;
        end
    end

    // Next-state and next-output logic; strobes and ready are computed one cycle ahead
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        cpu_ready_d = 1'b0;
        dma_ready_d = 1'b0;
        dma_wins    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    dma_wins = dma_req &
                               (~cpu_req | (streak_q == CNT_W'(MAX_CPU_STREAK)));
                    owner_d  = dma_wins;
                    wr_d     = dma_wins ? dma_write : cpu_write;
                    addr_d   = dma_wins ? dma_addr  : cpu_addr;
                    wdata_d  = dma_wins ? dma_wdata : cpu_wdata;
                    // Streak counts CPU grants that made a waiting DMA lose
                    if (dma_wins || !dma_req) begin
                        streak_d = '0;
                    end else if (streak_q != CNT_W'(MAX_CPU_STREAK)) begin
                        streak_d = streak_q + CNT_W'(1);
                    end
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    mem_read_d  = ~wr_d;
                    mem_write_d = wr_d;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        data_d = mem_rdata;
                    end
                    cpu_ready_d = ~owner_q;
                    dma_ready_d = owner_q;
                    state_d     = RESP;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_read_d  = ~wr_q;
                    mem_write_d = wr_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dma_ready = dma_ready_q;
    assign cpu_rdata = data_q;
    assign dma_rdata = data_q;
    assign cpu_stall = cpu_req & ~cpu_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, write/read path, starvation rotation,
// mid-access input changes and reset abandonment, against a small memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_write;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_ready;
    logic [31:0] dma_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int ncmp = 0;
    int nerr = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .MAX_CPU_STREAK(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one remembered write, fixed word at 0x10, address pattern elsewhere.
    // Read data is only valid in the second read cycle, garbage otherwise.
    logic [31:0] wr_addr_m, wr_word_m;
    logic        wr_valid_m;
    logic [3:0]  rd_cnt;

    always @(posedge clk) begin
        if (reset) begin
            wr_valid_m <= 1'b0;
            wr_addr_m  <= 32'd0;
            wr_word_m  <= 32'd0;
            rd_cnt     <= 4'd0;
        end else begin
            rd_cnt <= mem_read ? rd_cnt + 4'd1 : 4'd0;
            if (mem_write) begin
                wr_valid_m <= 1'b1;
                wr_addr_m  <= mem_addr;
                wr_word_m  <= mem_wdata;
            end
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0BAD0;
        if (mem_read && rd_cnt == 4'd1) begin
            if (wr_valid_m && mem_addr == wr_addr_m) mem_rdata = wr_word_m;
            else if (mem_addr == 32'h10)             mem_rdata = 32'hDEADBEEF;
            else                                     mem_rdata = {mem_addr[15:0], 16'hA5A5};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic exp_dma;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_write = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
        repeat (3) cyc();
        #1;
        chk1("rst_cpu_ready", cpu_ready, 1'b0);
        chk1("rst_dma_ready", dma_ready, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_mem_wdata", mem_wdata, 32'd0);
        chk32("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk1("rst_cpu_stall", cpu_stall, 1'b0);
        reset = 1'b0;
        cyc();

        // CPU read of 0x10; address changes mid-access must be ignored
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h10;
        #1;
        chk1("t1_c0_stall", cpu_stall, 1'b1);
        chk1("t1_c0_mem_read", mem_read, 1'b0);
        cyc();
        cpu_addr = 32'h20;
        #1;
        chk1("t1_c1_mem_read", mem_read, 1'b1);
        chk32("t1_c1_mem_addr", mem_addr, 32'h10);
        chk1("t1_c1_stall", cpu_stall, 1'b1);
        chk1("t1_c1_ready", cpu_ready, 1'b0);
        cyc();
        #1;
        chk1("t1_c2_mem_read", mem_read, 1'b1);
        chk32("t1_c2_mem_addr", mem_addr, 32'h10);
        chk1("t1_c2_stall", cpu_stall, 1'b1);
        cyc();
        #1;
        chk1("t1_c3_ready", cpu_ready, 1'b1);
        chk32("t1_c3_rdata", cpu_rdata, 32'hDEADBEEF);
        chk1("t1_c3_mem_read", mem_read, 1'b0);
        chk1("t1_c3_stall", cpu_stall, 1'b0);
        chk1("t1_c3_dma_ready", dma_ready, 1'b0);
        cpu_req = 1'b0; cpu_addr = 32'h10;
        cyc();

        // DMA write 0x1234 to 0x40
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234;
        cyc();
        #1;
        chk1("t2_w1_mem_write", mem_write, 1'b1);
        chk1("t2_w1_mem_read", mem_read, 1'b0);
        chk32("t2_w1_mem_addr", mem_addr, 32'h40);
        chk32("t2_w1_mem_wdata", mem_wdata, 32'h1234);
        cyc();
        #1;
        chk1("t2_w2_mem_write", mem_write, 1'b1);
        cyc();
        #1;
        chk1("t2_resp_dma_ready", dma_ready, 1'b1);
        chk1("t2_resp_cpu_ready", cpu_ready, 1'b0);
        chk1("t2_resp_mem_write", mem_write, 1'b0);
        chk32("t2_resp_dma_rdata", dma_rdata, 32'hDEADBEEF);
        dma_req = 1'b0;
        cyc();

        // CPU reads back 0x40
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40;
        cyc(); cyc(); cyc();
        #1;
        chk1("t2_rd_ready", cpu_ready, 1'b1);
        chk32("t2_rd_rdata", cpu_rdata, 32'h1234);
        cpu_req = 1'b0;
        cyc();

        // Both requests held: CPU x4 then DMA, repeating
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 32'h80;
        for (int g = 0; g < 10; g++) begin
            exp_dma = ((g % 5) == 4);
            if (g > 0) begin
                cyc();
                #1;
                chk1("st_idle_cpu_ready", cpu_ready, 1'b0);
                chk1("st_idle_dma_ready", dma_ready, 1'b0);
            end
            cyc(); cyc();
            #1;
            chk1("st_acc_dma_ready", dma_ready, 1'b0);
            chk32("st_acc_mem_addr", mem_addr, exp_dma ? 32'h80 : 32'h10);
            cyc();
            #1;
            chk1("st_resp_cpu_ready", cpu_ready, ~exp_dma);
            chk1("st_resp_dma_ready", dma_ready, exp_dma);
            chk32("st_resp_rdata", exp_dma ? dma_rdata : cpu_rdata,
                  exp_dma ? 32'h0080A5A5 : 32'hDEADBEEF);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        cyc();

        // CPU write abandoned by reset in its first ACCESS cycle
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h55;
        dma_req = 1'b1; dma_write = 1'b0;
        cyc();
        #1;
        chk1("rs_acc_mem_write", mem_write, 1'b1);
        chk32("rs_acc_mem_addr", mem_addr, 32'h44);
        chk32("rs_acc_streak", {28'd0, dut.streak_q}, 32'd1);
        reset = 1'b1;
        cyc();
        #1;
        chk1("rs_mem_write", mem_write, 1'b0);
        chk1("rs_mem_read", mem_read, 1'b0);
        chk1("rs_cpu_ready", cpu_ready, 1'b0);
        chk1("rs_dma_ready", dma_ready, 1'b0);
        chk32("rs_streak", {28'd0, dut.streak_q}, 32'd0);
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        cyc();
        #1;
        chk1("rs_after_cpu_ready", cpu_ready, 1'b0);
        chk1("rs_after_mem_write", mem_write, 1'b0);

        // Fresh CPU read after reset sees normal latency
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40;
        cyc(); cyc(); cyc();
        #1;
        chk1("pr_ready", cpu_ready, 1'b1);
        chk32("pr_rdata", cpu_rdata, 32'h0040A5A5);
        cpu_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified instruction/data memory between two requesters. The CPU requester is the multicycle core's memory path, driven by the control unit's IorD/MemRead/MemWrite sequencing. The DMA requester is the debug/DMA loader. Each access is sequenced over a fixed memory latency, and the block raises a stall so the control unit holds its current state until its access completes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles mem_read/mem_write held per access (legal 1..15)
- MAX_CPU_STREAK, 4, consecutive CPU grants allowed while DMA waits (legal 1..15)

Ports:
- clk  in  1  clock. All state updates on rising edge.
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request. Held high until cpu_ready.
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready is high after a read
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ready
- dma_req, dma_write, dma_addr, dma_wdata, dma_ready, dma_rdata: same as the cpu_* signals, for the DMA requester
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE
  - If no request: stay in IDLE. mem_read and mem_write are 0.
  - If any request: choose a winner and latch owner, write, addr and wdata into registers.
  - Load cnt = MEM_LATENCY-1 and go to ACCESS.
- Winner selection:
  - CPU wins by default.
  - DMA wins if dma_req & ~cpu_req.
  - DMA also wins if dma_req & cpu_req & streak == MAX_CPU_STREAK.
- Streak counter (4 bits):
  - Increments on a CPU grant made while dma_req = 1.
  - Clears to 0 on a DMA grant.
  - Clears to 0 on a CPU grant made while dma_req = 0.
  - Saturates at MAX_CPU_STREAK.
- ACCESS
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_read = ~wr_q and mem_write = wr_q, held for every ACCESS cycle.
  - cnt decrements each cycle.
  - When cnt == 0 on a read: capture mem_rdata into data_q.
  - When cnt == 0: go to RESP.
- RESP
  - The owner's ready output is 1 for exactly one cycle.
  - mem_read and mem_write are 0.
  - Go to IDLE next.
- cpu_rdata and dma_rdata both output data_q.
  - data_q updates only on reads.
  - data_q holds its value across writes.
- Requester inputs are ignored outside IDLE; changing them mid-access has no effect.
- A request that stays high after its ready pulse is treated as a new request at the following IDLE.
- The non-owner's ready output stays 0.

## Timing
- Reset: state=IDLE, cnt=0, streak=0, data_q=0.
  - cpu_ready, dma_ready, mem_read, mem_write = 0.
  - mem_addr, mem_wdata = 0.
- Latency: request sampled in IDLE at cycle T.
  - ACCESS occupies cycles T+1 .. T+MEM_LATENCY.
  - ready is high in cycle T+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Memory interface contract:
  - A write commits at the rising edge that ends the last ACCESS cycle.
  - A read's data is valid combinationally in the last ACCESS cycle.
- Simultaneous cpu_req and dma_req in IDLE: resolved by the priority and streak rule above. There is no tie-break beyond it.
- Reset asserted in ACCESS or RESP:
  - Next cycle is IDLE.
  - The in-flight access is abandoned and no ready pulse is issued.
  - mem_write drops the next cycle.
- cpu_stall follows cpu_req in the same cycle. It is low in the CPU's RESP cycle.

## Test plan
- CPU read, MEM_LATENCY=2, mem returns 0xDEADBEEF at addr 0x10; cpu_req rises at cycle 0.
  - mem_read high in cycles 1–2.
  - cpu_ready in cycle 3 with cpu_rdata = 0xDEADBEEF.
  - cpu_stall high in cycles 0–2.
- DMA write of 0x1234 to 0x40, then CPU read of 0x40.
  - mem_write high for 2 cycles with mem_addr = 0x40.
  - CPU subsequently reads 0x1234.
  - dma_rdata/data_q unchanged by the write.
- Starvation: cpu_req and dma_req held high continuously, MAX_CPU_STREAK=4.
  - Grant order is CPU, CPU, CPU, CPU, DMA, then repeating.
  - Exactly one ready pulse per grant.
- Both requests arrive in the same cycle with streak=0 → CPU is granted; dma_ready stays 0 until its own RESP.
- Change cpu_addr from 0x10 to 0x20 in the middle of ACCESS → mem_addr stays 0x10 for the whole access.
- Assert reset in the first ACCESS cycle of a CPU write.
  - Next cycle: mem_write = 0 and state = IDLE.
  - No cpu_ready pulse.
  - streak = 0.
